// File: rtl/spi_dma_wr_bst.sv
// spi_dma_wr_bst: burst DMA write channel that drains a show-ahead FIFO into Avalon-MM write bursts.
// Optional SPI_DMA_WR_BST_ALIGN4K_EN keeps every burst inside a single 4 KB page.
module spi_dma_wr_bst #(
  parameter int AL = 2,
  parameter int AW = 32,
  parameter int BL = 4,
  parameter int FW = 6,
  parameter int LW = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pio_adr_we,
  input  logic                  pio_len_we,
  input  logic [31:0]           pio_d,
  output logic [31:0]           pio_adr,
  output logic [31:0]           pio_len,
  output logic [31:0]           pio_cst,
  input  logic [BL:0]           burstcount,
  input  logic [FW:0]           dff_cnt,
  input  logic [8*(2**AL)-1:0]  dff_rdat,
  output logic                  dff_ack,
  output logic [AW-1:0]         avm_address,
  output logic [BL:0]           avm_burstcount,
  output logic                  avm_write,
  output logic [8*(2**AL)-1:0]  avm_writedata,
  input  logic                  avm_waitrequest,
  output logic                  done,
  output logic                  err
);
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [LW-1:0] MAXB = LW'(2**BL);
  state_t state_q, state_d;
  logic [AW-AL-1:0] adr_q, adr_d;
  logic [LW-AL-1:0] len_q, len_d;
  logic [BL:0] blen_q, blen_d, beats_q, beats_d;
  logic [LW-1:0] len_w, bc_w, bl_w, bw_w;
  logic unused_bits;
  assign unused_bits = ^pio_d[AL-1:0];
`ifdef SPI_DMA_WR_BST_ALIGN4K_EN
  logic [LW-1:0] rem_w;
`endif
  always_comb begin
    len_w = LW'(len_q);
    bc_w = burstcount == '0 ? LW'(1) : (LW'(burstcount) > MAXB ? MAXB : LW'(burstcount));
    bl_w = bc_w > len_w ? len_w : bc_w;
`ifdef SPI_DMA_WR_BST_ALIGN4K_EN
    rem_w = LW'(2**(12-AL)) - LW'(adr_q[11-AL:0]);
    bw_w = bl_w > rem_w ? rem_w : bl_w;
`else
    bw_w = bl_w;
`endif
  end
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    len_d = len_q;
    blen_d = blen_q;
    beats_d = beats_q;
    dff_ack = 1'b0;
    done = 1'b0;
    err = 1'b0;
    if (state_q == IDLE) begin
      if (pio_adr_we) adr_d = pio_d[AW-1:AL];
      if (pio_len_we) len_d = pio_d[LW-1:AL];
      // a PIO write this cycle defers the start so the next burst sees the new registers
      if (!pio_adr_we && !pio_len_we && len_q != '0 && LW'(dff_cnt) >= bw_w) begin
        state_d = BURST;
        blen_d = bw_w[BL:0];
        beats_d = bw_w[BL:0];
      end
    end else begin
      err = pio_adr_we | pio_len_we;
      dff_ack = ~avm_waitrequest;
      if (dff_ack) begin
        beats_d = beats_q - 1'b1;
        if (beats_q == (BL+1)'(1)) begin
          adr_d = adr_q + (AW-AL)'(blen_q);
          len_d = len_q - (LW-AL)'(blen_q);
          done = len_q == (LW-AL)'(blen_q);
          state_d = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q <= '0;
      len_q <= '0;
      blen_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      len_q <= len_d;
      blen_q <= blen_d;
      beats_q <= beats_d;
    end
  end
  assign avm_write = state_q == BURST;
  assign avm_address = {adr_q, {AL{1'b0}}};
  assign avm_burstcount = avm_write ? blen_q : '0;
  assign avm_writedata = dff_rdat;
  assign pio_adr = 32'({adr_q, {AL{1'b0}}});
  assign pio_len = 32'({len_q, {AL{1'b0}}});
  assign pio_cst = {avm_write | (len_q != '0), avm_write, 14'b0, 8'(beats_q), 8'b0} | 32'(dff_cnt);
endmodule

// File: doc/spi_dma_wr_bst.md
# spi_dma_wr_bst

Burst-mode DMA write channel: drains words from a show-ahead data FIFO and writes them to memory as Avalon-MM write bursts. It is the memory-write counterpart of the SPI DMA read channel. It shares that channel's PIO register model (byte address, byte length), burst sizing and FIFO-level gating. It sits between the SPI receive FIFO and the system bus master port.

## Interface
- AL, 2, address LSB; data width = 8*(2**AL)
- AW, 32, address width in bits
- BL, 4, max burst exponent; max burst = 2**BL words; BL in 1..7
- FW, 6, FIFO level width; FIFO size = 2**FW words; FW>=BL
- LW, 24, length register width in bytes
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pio_adr_we  in  1  load address register from pio_d
- pio_len_we  in  1  load length register from pio_d; starts the transfer
- pio_d  in  32  PIO write data (bytes)
- pio_adr  out  32  current address in bytes
- pio_len  out  32  remaining length in bytes
- pio_cst  out  32  status: [31]=busy, [30]=in burst, [15:8]=beats left in burst, [FW:0]=dff_cnt, other bits 0
- burstcount  in  BL+1  requested burst length in words
- dff_cnt  in  FW+1  words available in FIFO
- dff_rdat  in  8*2**AL  FIFO head word, valid when dff_cnt>0
- dff_ack  out  1  pop FIFO head
- avm_address  out  AW  byte address of burst, low AL bits 0
- avm_burstcount  out  BL+1  words in the current burst
- avm_write  out  1  write request
- avm_writedata  out  8*2**AL  equals dff_rdat
- avm_waitrequest  in  1  slave stall
- done  out  1  one-cycle pulse: last word of the transfer accepted
- err  out  1  one-cycle pulse: PIO write dropped because a burst was active

## Operation
- Registers: adr_reg[AW-1:AL] and len_reg (words) hold pio_d[AW-1:AL] and pio_d[LW-1:0]>>AL. Low AL bits are discarded. A transfer runs while len_reg!=0.
- Burst size bw is computed in IDLE from burstcount:
  - 0 -> 1
  - >2**BL -> 2**BL
  - >len_reg -> len_reg
- FSM IDLE: go to BURST when len_reg!=0 and dff_cnt>=bw. On entry, latch bw into burst_len and into beat counter beats=bw.
- FSM BURST:
  - avm_write=1. avm_address=adr_reg<<AL and avm_burstcount=burst_len stay constant for the whole burst.
  - A beat is accepted on any cycle with ~avm_waitrequest. On acceptance, dff_ack=1 (combinational) and beats decrements.
  - On the last beat: adr_reg += burst_len, len_reg -= burst_len, then go to IDLE.
- No data underflow can occur, because the burst starts only with bw words already in the FIFO.
- pio_adr_we / pio_len_we in IDLE: applied. Both may apply in the same cycle. pio_len_we overrides an active transfer between bursts.
- pio_adr_we / pio_len_we in BURST: ignored; err=1 for that cycle.
- done = last beat accepted && len_reg==burst_len.

## Timing
- Reset (rst_n low, asynchronous): FSM=IDLE; adr_reg, len_reg and beats = 0.
  - Outputs: avm_write=0, dff_ack=0, done=0, err=0, pio_adr=0, pio_len=0, avm_burstcount=0.
  - Reset mid-burst drops avm_write immediately. The partial burst is abandoned.
- pio_len_we in cycle N with data ready: avm_write=1 from cycle N+2. The IDLE evaluation uses the new len_reg in N+1.
- Burst of n beats without stalls: n cycles of avm_write. IDLE lasts exactly 1 cycle between back-to-back bursts.
- avm_burstcount reads 0 while in IDLE.
- pio_adr and pio_len update on the cycle after the last beat.

## Configuration
- SPI_DMA_WR_BST_ALIGN4K_EN defined: bw is further clamped to the words remaining before the next 4 KB address boundary, so no burst crosses 4 KB.
- Not defined: no boundary clamp; bursts may cross 4 KB.

## Test plan
All scenarios use AL=2, BL=4, FW=6.
- Basic two-burst transfer:
  - Stimulus: adr=0x1000, len=64 bytes, burstcount=8, dff_cnt=16, waitrequest=0.
  - Response: bursts at 0x1000 and 0x1020, burstcount 8 each, 16 dff_ack, done pulse on the 16th beat, pio_len=0, pio_adr=0x1040.
- Burst size clamping:
  - len=20 bytes, burstcount=8 -> single burst, burstcount=5.
  - burstcount=0 -> burstcount=1.
  - burstcount=31 -> burstcount=16.
- Stall and FIFO gating:
  - waitrequest held 3 cycles on beat 2 -> address, burstcount and writedata stable; dff_ack=0 during the stall; 8 beats total.
  - dff_cnt=3 with burstcount=4, len=16 bytes -> avm_write stays 0 until dff_cnt=4, then a 4-beat burst.
- PIO write during burst: pio_len_we mid-burst -> err pulse for 1 cycle; len_reg and burst unaffected.
- 4 KB boundary: adr=0xFF8, len=64 bytes, burstcount=16.
  - With the macro: burst of 2 at 0xFF8, then a burst of 14 at 0x1000.
  - Without the macro: a single burst of 16.
- Reset mid-burst: rst_n low on beat 3 -> avm_write=0 asynchronously, pio_len=0, no done.
